// File: rtl/universal_shift_engine.sv
// N-bit universal shift register with eight per-cycle modes plus a counted burst shifter.
// Optional parity output on Q is enabled by defining UR_PARITY_EN.
module universal_shift_engine #(
    parameter int N     = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       ctrl,
    input  logic [N-1:0]     D_in,
    input  logic             serial_in_r,
    input  logic             serial_in_l,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             burst_dir,
    output logic [N-1:0]     Q_out,
    output logic             serial_out_r,
    output logic             serial_out_l,
    output logic             busy,
    output logic             done
`ifdef UR_PARITY_EN
    ,
    output logic             parity_out
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [N-1:0]     q, q_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             dir, dir_next;
    logic             done_r, done_next;

    // Handshake: start is sampled only in IDLE; busy covers exactly the shift
    // cycles, and done is a one-cycle pulse after the last shift edge.
    always_comb begin
        state_next = state;
        q_next     = q;
        cnt_next   = cnt;
        dir_next   = dir;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    // start outranks ctrl; the register holds on the accept edge
                    if (burst_len != '0) begin
                        dir_next   = burst_dir;
                        cnt_next   = burst_len;
                        state_next = BUSY;
                    end else begin
                        done_next = 1'b1;
                    end
                end else begin
                    case (ctrl)
                        3'b001:  q_next = {serial_in_r, q[N-1:1]};
                        3'b010:  q_next = {q[N-2:0], serial_in_l};
                        3'b011:  q_next = D_in;
                        3'b100:  q_next = {q[0], q[N-1:1]};
                        3'b101:  q_next = {q[N-2:0], q[N-1]};
                        3'b110:  q_next = {q[N-1], q[N-1:1]};
                        3'b111:  q_next = '0;
                        default: q_next = q;
                    endcase
                end
            end
            BUSY: begin
                q_next   = dir ? {q[N-2:0], serial_in_l} : {serial_in_r, q[N-1:1]};
                cnt_next = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            q      <= '0;
            cnt    <= '0;
            dir    <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_next;
            q      <= q_next;
            cnt    <= cnt_next;
            dir    <= dir_next;
            done_r <= done_next;
        end
    end

`ifdef UR_PARITY_EN
    // Computed from q_next so the stored parity always matches the stored Q.
    logic parity_r;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) parity_r <= 1'b0;
        else        parity_r <= ^q_next;
    end
    assign parity_out = parity_r;
`endif

    assign Q_out        = q;
    assign serial_out_r = q[0];
    assign serial_out_l = q[N-1];
    assign busy         = (state == BUSY);
    assign done         = done_r;

endmodule

// File: tb/tb_universal_shift_engine.sv
// Directed bench for universal_shift_engine: reset, mode sweep, bursts, abort and back-to-back.
// Parity checks are included when UR_PARITY_EN is defined.
module tb_universal_shift_engine;

    logic       clk;
    logic       rst_n;
    logic [2:0] ctrl;
    logic [7:0] d_in;
    logic       serial_in_r;
    logic       serial_in_l;
    logic       start;
    logic [3:0] burst_len;
    logic       burst_dir;
    logic [7:0] q_out;
    logic       serial_out_r;
    logic       serial_out_l;
    logic       busy;
    logic       done;
`ifdef UR_PARITY_EN
    logic       parity_out;
`endif

    int n_cmp;
    int n_err;

    universal_shift_engine #(.N(8), .CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ctrl         (ctrl),
        .D_in         (d_in),
        .serial_in_r  (serial_in_r),
        .serial_in_l  (serial_in_l),
        .start        (start),
        .burst_len    (burst_len),
        .burst_dir    (burst_dir),
        .Q_out        (q_out),
        .serial_out_r (serial_out_r),
        .serial_out_l (serial_out_l),
        .busy         (busy),
        .done         (done)
`ifdef UR_PARITY_EN
        ,
        .parity_out   (parity_out)
`endif
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // inputs change on the falling edge; outputs are sampled on the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input logic [7:0] v);
        ctrl = 3'b011;
        d_in = v;
        step();
        ctrl = 3'b000;
    endtask

    logic [2:0] sweep_mode [7];
    logic [7:0] sweep_exp  [7];

    initial begin
        n_cmp = 0;
        n_err = 0;
        sweep_mode = '{3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111, 3'b000};
        sweep_exp  = '{8'h52, 8'h4B, 8'hD2, 8'h4B, 8'hD2, 8'h00, 8'hA5};

        rst_n = 1'b0;
        ctrl = 3'b011;
        d_in = 8'hA5;
        serial_in_r = 1'b0;
        serial_in_l = 1'b1;
        start = 1'b0;
        burst_len = 4'd0;
        burst_dir = 1'b0;

        // reset holds Q at zero even with a load requested
        step();
        step();
        check_val("rst_q", q_out, 8'h00);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
`ifdef UR_PARITY_EN
        check_val("rst_parity", parity_out, 1'b0);
`endif

        rst_n = 1'b1;
        step();
        check_val("load_q", q_out, 8'hA5);
        check_val("load_sor", serial_out_r, 1'b1);
        check_val("load_sol", serial_out_l, 1'b1);
`ifdef UR_PARITY_EN
        check_val("load_parity", parity_out, 1'b0);
`endif

        for (int i = 0; i < 7; i++) begin
            load(8'hA5);
            ctrl = sweep_mode[i];
            step();
            check_val($sformatf("mode_%b", sweep_mode[i]), q_out, sweep_exp[i]);
        end
        ctrl = 3'b000;

        // burst of 3 to the right; clear on ctrl must be ignored while busy
        load(8'h81);
        start = 1'b1;
        burst_len = 4'd3;
        burst_dir = 1'b0;
        serial_in_r = 1'b0;
        step();
        start = 1'b0;
        ctrl = 3'b111;
        check_val("b3_c0_busy", busy, 1'b1);
        check_val("b3_c0_q", q_out, 8'h81);
        check_val("b3_c0_done", done, 1'b0);
        step();
        check_val("b3_c1_busy", busy, 1'b1);
        check_val("b3_c1_q", q_out, 8'h40);
`ifdef UR_PARITY_EN
        check_val("b3_c1_parity", parity_out, 1'b1);
`endif
        step();
        check_val("b3_c2_busy", busy, 1'b1);
        check_val("b3_c2_q", q_out, 8'h20);
        step();
        ctrl = 3'b000;
        check_val("b3_end_busy", busy, 1'b0);
        check_val("b3_end_done", done, 1'b1);
        check_val("b3_end_q", q_out, 8'h10);
        step();
        check_val("b3_post_done", done, 1'b0);
        check_val("b3_post_q", q_out, 8'h10);

        // zero-length burst
        start = 1'b1;
        burst_len = 4'd0;
        step();
        start = 1'b0;
        check_val("b0_busy", busy, 1'b0);
        check_val("b0_done", done, 1'b1);
        check_val("b0_q", q_out, 8'h10);
        step();
        check_val("b0_post_done", done, 1'b0);
        check_val("b0_post_busy", busy, 1'b0);

        // reset mid-burst after four busy cycles
        load(8'hFF);
        start = 1'b1;
        burst_len = 4'd10;
        burst_dir = 1'b0;
        serial_in_r = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check_val("abort_pre_busy", busy, 1'b1);
        check_val("abort_pre_q", q_out, 8'h1F);
        rst_n = 1'b0;
        #1;
        check_val("abort_q", q_out, 8'h00);
        check_val("abort_busy", busy, 1'b0);
        check_val("abort_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_val("abort_post_done", done, 1'b0);
        check_val("abort_post_busy", busy, 1'b0);
        start = 1'b1;
        burst_len = 4'd1;
        burst_dir = 1'b1;
        serial_in_l = 1'b1;
        step();
        start = 1'b0;
        check_val("restart_busy", busy, 1'b1);
        step();
        check_val("restart_done", done, 1'b1);
        check_val("restart_q", q_out, 8'h01);

        // back-to-back: second start held on the done cycle
        load(8'h81);
        start = 1'b1;
        burst_len = 4'd1;
        burst_dir = 1'b0;
        serial_in_r = 1'b0;
        step();
        burst_len = 4'd2;
        burst_dir = 1'b1;
        serial_in_l = 1'b1;
        check_val("bb_first_busy", busy, 1'b1);
        step();
        check_val("bb_done", done, 1'b1);
        check_val("bb_done_q", q_out, 8'h40);
        step();
        start = 1'b0;
        check_val("bb_second_busy", busy, 1'b1);
        check_val("bb_second_done", done, 1'b0);
        check_val("bb_second_q", q_out, 8'h40);
        step();
        check_val("bb_s1_busy", busy, 1'b1);
        check_val("bb_s1_q", q_out, 8'h81);
        step();
        check_val("bb_end_busy", busy, 1'b0);
        check_val("bb_end_done", done, 1'b1);
        check_val("bb_end_q", q_out, 8'h03);
`ifdef UR_PARITY_EN
        check_val("bb_end_parity", parity_out, 1'b0);
`endif
        step();
        check_val("bb_post_done", done, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
